xmpl_dec: RTL and testbench

- Decimating accumulator that sits directly downstream of the xmpl_dsp_core filter stage.
- Consumes the 23-bit signed filter result and its status flag one sample per qualified cycle.
- Averages every 2^DEC_LOG2 samples with rounding and reduces the result to OUT_W bits.
- Buffers results in a small output FIFO behind a valid/ready handshake toward the next stage.

---
 rtl/xmpl_dec.sv | 160 ++++++++++++++++
 tb/tb_xmpl_dec.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/xmpl_dec.sv
// xmpl_dec -- decimating accumulator behind the xmpl_dsp_core filter stage.
//
// Sums 2^DEC_LOG2 accepted filter samples, rounds the sum half-up to the window
// average, reduces the average to OUT_W bits and queues it, together with the
// OR of the per-sample status flags, in a small output FIFO drained through a
// valid/ready handshake.
//
// Build option:
//   XMPL_DEC_SAT_EN  defined   : average saturates to the signed OUT_W range
//                    undefined : average wraps to its low OUT_W bits
//
// Ports:
//   clk_i         in   clock, rising edge
//   reset_i       in   synchronous active-high reset
//   en_dec_i      in   block enable; low clears the partial window
//   flt_vld_i     in   filter sample valid
//   flt_c23_i     in   23-bit two's complement filter sample
//   flt_status_i  in   status flag of the current sample
//   dec_vld_o     out  FIFO head valid
//   dec_rdy_i     in   downstream ready
//   dec_data_o    out  decimated sample (signed, OUT_W bits)
//   dec_status_o  out  OR of status flags over the window
//   ovf_o         out  sticky FIFO overflow flag
//   ovf_clr_i     in   clears ovf_o
module xmpl_dec #(
    parameter int DEC_LOG2   = 2,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_dec_i,
    input  logic             flt_vld_i,
    input  logic [22:0]      flt_c23_i,
    input  logic             flt_status_i,
    output logic             dec_vld_o,
    input  logic             dec_rdy_i,
    output logic [OUT_W-1:0] dec_data_o,
    output logic             dec_status_o,
    output logic             ovf_o,
    input  logic             ovf_clr_i
);

    localparam int N     = 1 << DEC_LOG2;
    localparam int ACC_W = 23 + DEC_LOG2;
    localparam int RND_W = 24 + DEC_LOG2;
    localparam int CNT_W = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    // Half an LSB of the average; zero when N=1 so the add vanishes.
    localparam logic signed [RND_W-1:0] HALF = RND_W'(N >> 1);

`ifdef XMPL_DEC_SAT_EN
    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN = -SAT_MAX - RND_W'(1);
`endif

    function automatic logic signed [RND_W-1:0] round_avg(input logic signed [ACC_W-1:0] a);
        logic signed [RND_W-1:0] w;
        w = RND_W'(a) + HALF;
        return w >>> DEC_LOG2;
    endfunction

    function automatic logic signed [OUT_W-1:0] reduce(input logic signed [RND_W-1:0] r);
`ifdef XMPL_DEC_SAT_EN
        if (r > SAT_MAX)      return OUT_W'(SAT_MAX);
        else if (r < SAT_MIN) return OUT_W'(SAT_MIN);
        else                  return OUT_W'(r);
`else
        return OUT_W'(r);
`endif
    endfunction

    // ---------------- stage p0: window accumulation ----------------
    logic signed [22:0]      smp_p0;
    logic signed [ACC_W-1:0] acc_p0;
    logic signed [ACC_W-1:0] acc_final_p0;
    logic                    stat_p0;
    logic [CNT_W-1:0]        cnt_p0;
    logic                    accept_p0;
    logic                    last_p0;
    logic                    vld_p0;
    logic signed [OUT_W-1:0] res_p0;
    logic                    res_stat_p0;

    assign smp_p0       = flt_c23_i;
    assign accept_p0    = flt_vld_i && en_dec_i;
    assign last_p0      = (cnt_p0 == CNT_W'(N - 1));
    assign vld_p0       = accept_p0 && last_p0;
    // Final sample joins the sum combinationally so the result is pushed this edge.
    assign acc_final_p0 = acc_p0 + ACC_W'(smp_p0);
    assign res_p0       = reduce(round_avg(acc_final_p0));
    assign res_stat_p0  = stat_p0 | flt_status_i;

    always_ff @(posedge clk_i) begin
        if (reset_i || !en_dec_i) begin
            acc_p0  <= '0;
            stat_p0 <= 1'b0;
            cnt_p0  <= '0;
        end else if (accept_p0) begin
            if (last_p0) begin
                acc_p0  <= '0;
                stat_p0 <= 1'b0;
                cnt_p0  <= '0;
            end else begin
                acc_p0  <= acc_final_p0;
                stat_p0 <= res_stat_p0;
                cnt_p0  <= cnt_p0 + CNT_W'(1);
            end
        end
    end

    // ---------------- stage p1: output FIFO ----------------
    logic signed [OUT_W-1:0] mem_data_p1 [FIFO_DEPTH];
    logic                    mem_stat_p1 [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_p1;
    logic [PTR_W-1:0]        rd_ptr_p1;
    logic [PTR_W:0]          count_p1;
    logic                    full_p1;
    logic                    pop_p1;
    logic                    push_ok_p1;

    assign full_p1    = (count_p1 == (PTR_W + 1)'(FIFO_DEPTH));
    assign dec_vld_o  = (count_p1 != '0);
    assign pop_p1     = dec_vld_o && dec_rdy_i;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok_p1 = vld_p0 && (!full_p1 || pop_p1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            count_p1  <= '0;
        end else begin
            if (push_ok_p1) wr_ptr_p1 <= PTR_W'((wr_ptr_p1 + 1'b1) % FIFO_DEPTH);
            if (pop_p1)     rd_ptr_p1 <= PTR_W'((rd_ptr_p1 + 1'b1) % FIFO_DEPTH);
            if (push_ok_p1 && !pop_p1)      count_p1 <= count_p1 + 1'b1;
            else if (!push_ok_p1 && pop_p1) count_p1 <= count_p1 - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_p1) begin
            mem_data_p1[wr_ptr_p1] <= res_p0;
            mem_stat_p1[wr_ptr_p1] <= res_stat_p0;
        end
    end

    // Entries are not reset, so the head is masked while the FIFO is empty.
    assign dec_data_o   = dec_vld_o ? mem_data_p1[rd_ptr_p1] : '0;
    assign dec_status_o = dec_vld_o ? mem_stat_p1[rd_ptr_p1] : 1'b0;

    // Overflow takes priority over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (reset_i)                         ovf_o <= 1'b0;
        else if (vld_p0 && full_p1 && !pop_p1) ovf_o <= 1'b1;
        else if (ovf_clr_i)                  ovf_o <= 1'b0;
    end

endmodule

// File: tb/tb_xmpl_dec.sv
module tb_xmpl_dec;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        en_dec_i;
    logic        flt_vld_i;
    logic [22:0] flt_c23_i;
    logic        flt_status_i;
    logic        dec_vld_o;
    logic        dec_rdy_i;
    logic [15:0] dec_data_o;
    logic        dec_status_o;
    logic        ovf_o;
    logic        ovf_clr_i;

    xmpl_dec #(.DEC_LOG2(2), .OUT_W(16), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_dec_i(en_dec_i),
        .flt_vld_i(flt_vld_i), .flt_c23_i(flt_c23_i), .flt_status_i(flt_status_i),
        .dec_vld_o(dec_vld_o), .dec_rdy_i(dec_rdy_i), .dec_data_o(dec_data_o),
        .dec_status_o(dec_status_o), .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] data;
        logic        st;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_out(input int data, input logic st);
        exp_t e;
        e.data = 16'(data);
        e.st   = st;
        sb.push_back(e);
    endtask

    task automatic send(input int v, input logic st);
        flt_vld_i    = 1'b1;
        flt_c23_i    = 23'(v);
        flt_status_i = st;
        @(posedge clk_i);
        #1;
        flt_vld_i    = 1'b0;
        flt_status_i = 1'b0;
    endtask

    task automatic send4(input int v);
        for (int i = 0; i < 4; i++) send(v, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Monitor: every handshake pops one expected result and compares.
    always @(negedge clk_i) begin
        if (!reset_i && dec_vld_o && dec_rdy_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data 0x%0h, expected no output", dec_data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 32'(dec_data_o), 32'(e.data));
                check("out_status", 32'(dec_status_o), 32'(e.st));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; en_dec_i = 1'b1; flt_vld_i = 1'b0; flt_c23_i = '0;
        flt_status_i = 1'b0; dec_rdy_i = 1'b1; ovf_clr_i = 1'b0;
        idle(3);
        check("rst_vld", 32'(dec_vld_o), 32'd0);
        check("rst_data", 32'(dec_data_o), 32'd0);
        check("rst_status", 32'(dec_status_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        reset_i = 1'b0;
        idle(1);

        // Basic average: (46+2)>>2 = 12, one cycle after the 4th sample.
        expect_out(12, 1'b0);
        send(10, 1'b0); send(11, 1'b0); send(12, 1'b0);
        check("lat_before", 32'(dec_vld_o), 32'd0);
        send(13, 1'b0);
        check("lat_vld", 32'(dec_vld_o), 32'd1);
        check("lat_data", 32'(dec_data_o), 32'd12);
        idle(2);

        // Negative rounding: (-23+2)>>>2 = -6.
        expect_out(-6, 1'b0);
        send(-5, 1'b0); send(-6, 1'b0); send(-6, 1'b0); send(-6, 1'b0);
        idle(2);

        // Large input: average 0x3FFFFF.
`ifdef XMPL_DEC_SAT_EN
        expect_out(32'h7FFF, 1'b0);
`else
        expect_out(32'hFFFF, 1'b0);
`endif
        send4(32'h3FFFFF);
        idle(2);

        // Status: window A (1,2,3,4; flag on 2nd) -> 3 with status; B -> 4 without.
        expect_out(3, 1'b1);
        send(1, 1'b0); send(2, 1'b1); send(3, 1'b0); send(4, 1'b0);
        expect_out(4, 1'b0);
        send4(4);
        idle(2);

        // Abort: partial window discarded by en_dec_i low.
        send(50, 1'b0); send(50, 1'b0);
        en_dec_i = 1'b0;
        idle(1);
        en_dec_i = 1'b1;
        expect_out(100, 1'b0);
        send4(100);
        idle(2);
        check("abort_drained", 32'(sb.size()), 32'd0);

        // Backpressure and overflow.
        dec_rdy_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) expect_out(1000 * k, 1'b0);
            send4(1000 * k);
            check("bp_vld", 32'(dec_vld_o), 32'd1);
            check("bp_head", 32'(dec_data_o), 32'd1000);
            if (k == 4) check("bp_no_ovf_yet", 32'(ovf_o), 32'd0);
        end
        check("ovf_set", 32'(ovf_o), 32'd1);
        idle(2);
        check("ovf_sticky", 32'(ovf_o), 32'd1);
        dec_rdy_i = 1'b1;
        idle(6);
        check("bp_drained_vld", 32'(dec_vld_o), 32'd0);
        check("bp_drained_sb", 32'(sb.size()), 32'd0);
        ovf_clr_i = 1'b1;
        idle(1);
        ovf_clr_i = 1'b0;
        check("ovf_cleared", 32'(ovf_o), 32'd0);

        // Reset mid-operation with two entries pending and a partial window.
        dec_rdy_i = 1'b0;
        send4(7);
        send4(7);
        check("pend_vld", 32'(dec_vld_o), 32'd1);
        send(8, 1'b0); send(8, 1'b0); send(8, 1'b0);
        reset_i = 1'b1;
        idle(1);
        reset_i = 1'b0;
        check("rst_mid_vld", 32'(dec_vld_o), 32'd0);
        dec_rdy_i = 1'b1;
        expect_out(8, 1'b0);
        send4(8);
        idle(3);

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_vld", 32'(dec_vld_o), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
